// File: rtl/vx_dispatch_unit_split_if.sv
// Handshake bundles between the operand/dispatch stage and the execute lane blocks.
// Every issue slot (or output block) is one element of each packed array.
interface vx_dispatch_if #(
   parameter int N      = 4,
   parameter int NT     = 4,
   parameter int XLEN   = 32,
   parameter int UUID_W = 8,
   parameter int WIS_W  = 1,
   parameter int OP_W   = 4,
   parameter int MOD_W  = 3,
   parameter int PC_W   = 32,
   parameter int RD_W   = 5,
   parameter int TID_W  = 2
);
   logic [N-1:0]                   valid;
   logic [N-1:0]                   ready;
   logic [N-1:0][UUID_W-1:0]       uuid;
   logic [N-1:0][WIS_W-1:0]        wis;
   logic [N-1:0][NT-1:0]           tmask;
   logic [N-1:0][OP_W-1:0]         op;
   logic [N-1:0][MOD_W-1:0]        op_mod;
   logic [N-1:0]                   wb;
   logic [N-1:0]                   use_pc;
   logic [N-1:0]                   use_imm;
   logic [N-1:0][PC_W-1:0]         pc;
   logic [N-1:0][XLEN-1:0]         imm;
   logic [N-1:0][RD_W-1:0]         rd;
   logic [N-1:0][TID_W-1:0]        tid;
   logic [N-1:0][NT-1:0][XLEN-1:0] rs1_data;
   logic [N-1:0][NT-1:0][XLEN-1:0] rs2_data;
   logic [N-1:0][NT-1:0][XLEN-1:0] rs3_data;

   modport master (
      output valid, uuid, wis, tmask, op, op_mod, wb, use_pc, use_imm, pc, imm, rd, tid,
             rs1_data, rs2_data, rs3_data,
      input  ready
   );
   modport slave (
      input  valid, uuid, wis, tmask, op, op_mod, wb, use_pc, use_imm, pc, imm, rd, tid,
             rs1_data, rs2_data, rs3_data,
      output ready
   );
endinterface

interface vx_execute_if #(
   parameter int N      = 2,
   parameter int NL     = 2,
   parameter int XLEN   = 32,
   parameter int UUID_W = 8,
   parameter int WID_W  = 3,
   parameter int OP_W   = 4,
   parameter int MOD_W  = 3,
   parameter int PC_W   = 32,
   parameter int RD_W   = 5,
   parameter int TID_W  = 2,
   parameter int PID_W  = 1
);
   logic [N-1:0]                   valid;
   logic [N-1:0]                   ready;
   logic [N-1:0][UUID_W-1:0]       uuid;
   logic [N-1:0][WID_W-1:0]        wid;
   logic [N-1:0][NL-1:0]           tmask;
   logic [N-1:0][OP_W-1:0]         op;
   logic [N-1:0][MOD_W-1:0]        op_mod;
   logic [N-1:0]                   wb;
   logic [N-1:0]                   use_pc;
   logic [N-1:0]                   use_imm;
   logic [N-1:0][PC_W-1:0]         pc;
   logic [N-1:0][XLEN-1:0]         imm;
   logic [N-1:0][RD_W-1:0]         rd;
   logic [N-1:0][TID_W-1:0]        tid;
   logic [N-1:0][NL-1:0][XLEN-1:0] rs1_data;
   logic [N-1:0][NL-1:0][XLEN-1:0] rs2_data;
   logic [N-1:0][NL-1:0][XLEN-1:0] rs3_data;
   logic [N-1:0][PID_W-1:0]        pid;
   logic [N-1:0]                   sop;
   logic [N-1:0]                   eop;

   modport master (
      output valid, uuid, wid, tmask, op, op_mod, wb, use_pc, use_imm, pc, imm, rd, tid,
             rs1_data, rs2_data, rs3_data, pid, sop, eop,
      input  ready
   );
   modport slave (
      input  valid, uuid, wid, tmask, op, op_mod, wb, use_pc, use_imm, pc, imm, rd, tid,
             rs1_data, rs2_data, rs3_data, pid, sop, eop,
      output ready
   );
endinterface

// File: rtl/vx_dispatch_unit_split.sv
// Per-block round-robin dispatch that splits warps into NUM_LANES-wide packets (empty ones skipped).
// Latency 0 (OUT_REG=0) or 1 cycle; execute ready low stalls the current packet in place.
module vx_dispatch_unit_split #(
   parameter int NUM_THREADS = 4,
   parameter int ISSUE_WIDTH = 4,
   parameter int NUM_WARPS   = 8,
   parameter int XLEN        = 32,
   parameter int UUID_W      = 8,
   parameter int OP_W        = 4,
   parameter int MOD_W       = 3,
   parameter int PC_W        = 32,
   parameter int RD_W        = 5,
   parameter int BLOCK_SIZE  = 1,
   parameter int NUM_LANES   = 1,
   parameter int OUT_REG     = 0,
   parameter int MAX_FANOUT  = 8
) (
   input  logic         clk,
   input  logic         reset,
   vx_dispatch_if.slave dispatch_if,
   vx_execute_if.master execute_if
);
   localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
   localparam int BATCH_COUNT = ISSUE_WIDTH / BLOCK_SIZE;
   localparam int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
   localparam int BC_W        = (BATCH_COUNT > 1) ? $clog2(BATCH_COUNT) : 1;
   localparam int ISW_W       = $clog2(ISSUE_WIDTH);
   localparam int SLOT_W      = (ISSUE_WIDTH > 1) ? ISW_W : 1;
   localparam int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int WIS_W       = (WID_W > ISW_W) ? (WID_W - ISW_W) : 1;
   localparam int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

   typedef struct packed {
      logic [UUID_W-1:0]                uuid;
      logic [WID_W-1:0]                 wid;
      logic [NUM_LANES-1:0]             tmask;
      logic [OP_W-1:0]                  op;
      logic [MOD_W-1:0]                 op_mod;
      logic                             wb;
      logic                             use_pc;
      logic                             use_imm;
      logic [PC_W-1:0]                  pc;
      logic [XLEN-1:0]                  imm;
      logic [RD_W-1:0]                  rd;
      logic [TID_W-1:0]                 tid;
      logic [NUM_LANES-1:0][XLEN-1:0]   rs1;
      logic [NUM_LANES-1:0][XLEN-1:0]   rs2;
      logic [NUM_LANES-1:0][XLEN-1:0]   rs3;
      logic [PID_WIDTH-1:0]             pid;
      logic                             sop;
      logic                             eop;
   } pkt_t;

   for (genvar b = 0; b < BLOCK_SIZE; b++) begin : g_blk
      logic                    blk_rst;
      logic [BATCH_COUNT-1:0]  blk_vld;
      logic [BC_W-1:0]         rr_ptr_q, rr_ptr_d, sel_k_q, sel_k_d, cand_k, sel;
      logic                    locked_q, locked_d, cand_vld;
      logic [PID_WIDTH-1:0]    pid_q, pid_d, pid_cur, first_pid, next_pid;
      logic [NUM_PACKETS-1:0]  pkt_act;
      logic [NUM_THREADS-1:0]  sel_tmask;
      logic [SLOT_W-1:0]       slot;
      logic [WID_W-1:0]        sel_wid;
      logic                    in_vld, in_rdy, in_fire, last_pkt;
      logic                    out_vld, out_rdy;
      pkt_t                    in_pkt, out_pkt;

      // Wide configurations get a registered reset copy per block.
      if (BLOCK_SIZE > MAX_FANOUT) begin : g_relay
         logic rst_q;
         always_ff @(posedge clk) rst_q <= reset;
         assign blk_rst = rst_q;
      end else begin : g_direct
         assign blk_rst = reset;
      end

      for (genvar k = 0; k < BATCH_COUNT; k++) begin : g_slot
         assign blk_vld[k] = dispatch_if.valid[k*BLOCK_SIZE + b];
         assign dispatch_if.ready[k*BLOCK_SIZE + b] = in_fire & last_pkt & (sel == BC_W'(k));
      end

      always_comb begin
         int              idx;
         logic [BC_W-1:0] idx_w;
         idx      = 0;
         idx_w    = '0;
         cand_k   = rr_ptr_q;
         cand_vld = 1'b0;
         // Scan downward so the lowest rotated offset from rr_ptr wins.
         for (int k = BATCH_COUNT - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= BATCH_COUNT) idx = idx - BATCH_COUNT;
            idx_w = BC_W'(idx);
            if (blk_vld[idx_w]) begin
               cand_k   = idx_w;
               cand_vld = 1'b1;
            end
         end
      end

      assign sel       = locked_q ? sel_k_q : cand_k;
      assign slot      = SLOT_W'(int'(sel) * BLOCK_SIZE + b);
      assign sel_tmask = dispatch_if.tmask[slot];
      assign in_vld    = ~blk_rst & blk_vld[sel];
      assign in_fire   = in_vld & in_rdy;

      if (ISSUE_WIDTH > 1) begin : g_wid_isw
         assign sel_wid = WID_W'({dispatch_if.wis[slot], slot});
      end else begin : g_wid_wis
         assign sel_wid = WID_W'(dispatch_if.wis[slot]);
      end

      for (genvar p = 0; p < NUM_PACKETS; p++) begin : g_act
         assign pkt_act[p] = |sel_tmask[p*NUM_LANES +: NUM_LANES];
      end

      always_comb begin
         first_pid = '0;
         for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
            if (pkt_act[p]) first_pid = PID_WIDTH'(p);
         end
      end

      assign pid_cur = locked_q ? pid_q : first_pid;

      always_comb begin
         next_pid = '0;
         last_pkt = 1'b1;
         for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
            if (pkt_act[p] && (p > int'(pid_cur))) begin
               next_pid = PID_WIDTH'(p);
               last_pkt = 1'b0;
            end
         end
      end

      always_comb begin
         in_pkt         = '0;
         in_pkt.uuid    = dispatch_if.uuid[slot];
         in_pkt.wid     = sel_wid;
         in_pkt.tmask   = sel_tmask[pid_cur*NUM_LANES +: NUM_LANES];
         in_pkt.op      = dispatch_if.op[slot];
         in_pkt.op_mod  = dispatch_if.op_mod[slot];
         in_pkt.wb      = dispatch_if.wb[slot];
         in_pkt.use_pc  = dispatch_if.use_pc[slot];
         in_pkt.use_imm = dispatch_if.use_imm[slot];
         in_pkt.pc      = dispatch_if.pc[slot];
         in_pkt.imm     = dispatch_if.imm[slot];
         in_pkt.rd      = dispatch_if.rd[slot];
         in_pkt.tid     = dispatch_if.tid[slot];
         in_pkt.rs1     = dispatch_if.rs1_data[slot][pid_cur*NUM_LANES +: NUM_LANES];
         in_pkt.rs2     = dispatch_if.rs2_data[slot][pid_cur*NUM_LANES +: NUM_LANES];
         in_pkt.rs3     = dispatch_if.rs3_data[slot][pid_cur*NUM_LANES +: NUM_LANES];
         in_pkt.pid     = pid_cur;
         in_pkt.sop     = (pid_cur == first_pid);
         in_pkt.eop     = last_pkt;
      end

      always_comb begin
         rr_ptr_d = rr_ptr_q;
         locked_d = locked_q;
         sel_k_d  = sel_k_q;
         pid_d    = pid_q;
         if (in_fire) begin
            if (last_pkt) begin
               locked_d = 1'b0;
               pid_d    = '0;
               rr_ptr_d = (sel == BC_W'(BATCH_COUNT - 1)) ? '0 : sel + BC_W'(1);
            end else begin
               locked_d = 1'b1;
               sel_k_d  = sel;
               pid_d    = next_pid;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (blk_rst) begin
            rr_ptr_q <= '0;
            locked_q <= 1'b0;
            sel_k_q  <= '0;
            pid_q    <= '0;
         end else begin
            rr_ptr_q <= rr_ptr_d;
            locked_q <= locked_d;
            sel_k_q  <= sel_k_d;
            pid_q    <= pid_d;
         end
      end

      if (OUT_REG == 0) begin : g_pass
         assign out_vld = in_vld;
         assign in_rdy  = out_rdy;
         assign out_pkt = in_pkt;
      end else if (OUT_REG == 1) begin : g_reg
         logic vld_q;
         pkt_t dat_q;
         assign in_rdy  = ~vld_q | out_rdy;
         assign out_vld = vld_q;
         assign out_pkt = dat_q;
         always_ff @(posedge clk) begin
            if (blk_rst)     vld_q <= 1'b0;
            else if (in_rdy) vld_q <= in_vld;
         end
         always_ff @(posedge clk) begin
            if (in_fire) dat_q <= in_pkt;
         end
      end else begin : g_skid
         logic main_vld_q, skid_vld_q;
         pkt_t main_q, skid_q;
         assign in_rdy  = ~skid_vld_q;
         assign out_vld = main_vld_q;
         assign out_pkt = main_q;
         always_ff @(posedge clk) begin
            if (blk_rst) begin
               main_vld_q <= 1'b0;
               skid_vld_q <= 1'b0;
            end else if (out_rdy | ~main_vld_q) begin
               main_vld_q <= skid_vld_q | in_vld;
               skid_vld_q <= 1'b0;
            end else if (in_vld & ~skid_vld_q) begin
               skid_vld_q <= 1'b1;
            end
         end
         // Skid entry drains into main before new input is accepted.
         always_ff @(posedge clk) begin
            if (out_rdy | ~main_vld_q) main_q <= skid_vld_q ? skid_q : in_pkt;
            else if (in_vld & ~skid_vld_q) skid_q <= in_pkt;
         end
      end

      assign out_rdy                = execute_if.ready[b];
      assign execute_if.valid[b]    = out_vld;
      assign execute_if.uuid[b]     = out_pkt.uuid;
      assign execute_if.wid[b]      = out_pkt.wid;
      assign execute_if.tmask[b]    = out_pkt.tmask;
      assign execute_if.op[b]       = out_pkt.op;
      assign execute_if.op_mod[b]   = out_pkt.op_mod;
      assign execute_if.wb[b]       = out_pkt.wb;
      assign execute_if.use_pc[b]   = out_pkt.use_pc;
      assign execute_if.use_imm[b]  = out_pkt.use_imm;
      assign execute_if.pc[b]       = out_pkt.pc;
      assign execute_if.imm[b]      = out_pkt.imm;
      assign execute_if.rd[b]       = out_pkt.rd;
      assign execute_if.tid[b]      = out_pkt.tid;
      assign execute_if.rs1_data[b] = out_pkt.rs1;
      assign execute_if.rs2_data[b] = out_pkt.rs2;
      assign execute_if.rs3_data[b] = out_pkt.rs3;
      assign execute_if.pid[b]      = out_pkt.pid;
      assign execute_if.sop[b]      = out_pkt.sop;
      assign execute_if.eop[b]      = out_pkt.eop;
   end
endmodule

// File: tb/tb_vx_dispatch_unit_split.sv
// Directed bench: NUM_THREADS=4, NUM_LANES=2, ISSUE_WIDTH=4, BLOCK_SIZE=2, OUT_REG=0.
module tb_vx_dispatch_unit_split;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   vx_dispatch_if #(.N(4), .NT(4), .XLEN(32), .UUID_W(8), .WIS_W(1), .OP_W(4), .MOD_W(3),
                    .PC_W(32), .RD_W(5), .TID_W(2)) dif ();
   vx_execute_if  #(.N(2), .NL(2), .XLEN(32), .UUID_W(8), .WID_W(3), .OP_W(4), .MOD_W(3),
                    .PC_W(32), .RD_W(5), .TID_W(2), .PID_W(1)) eif ();

   vx_dispatch_unit_split #(
      .NUM_THREADS(4), .ISSUE_WIDTH(4), .NUM_WARPS(8), .XLEN(32), .UUID_W(8), .OP_W(4),
      .MOD_W(3), .PC_W(32), .RD_W(5), .BLOCK_SIZE(2), .NUM_LANES(2), .OUT_REG(0), .MAX_FANOUT(8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .dispatch_if (dif),
      .execute_if  (eif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Lane i of rs1 carries base+i, rs2 carries base+16+i; wis follows uuid bit 0.
   task automatic set_slot(input int s, input logic v, input logic [3:0] tm,
                           input logic [7:0] uid, input logic [31:0] base);
      dif.valid[s]   = v;
      dif.tmask[s]   = tm;
      dif.uuid[s]    = uid;
      dif.wis[s]     = uid[0];
      dif.op[s]      = 4'h3;
      dif.op_mod[s]  = 3'h1;
      dif.wb[s]      = 1'b1;
      dif.use_pc[s]  = 1'b0;
      dif.use_imm[s] = 1'b1;
      dif.pc[s]      = 32'h8000_0000;
      dif.imm[s]     = 32'h44;
      dif.rd[s]      = 5'd7;
      dif.tid[s]     = 2'd0;
      for (int i = 0; i < 4; i++) begin
         dif.rs1_data[s][i] = base + 32'(i);
         dif.rs2_data[s][i] = base + 32'(16 + i);
         dif.rs3_data[s][i] = 32'h0;
      end
   endtask

   function automatic logic [63:0] lanes(input logic [31:0] base, input int pid);
      logic [31:0] lo, hi;
      lo = base + 32'(2*pid);
      hi = base + 32'(2*pid + 1);
      return {hi, lo};
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      eif.ready = 2'b00;
      for (int s = 0; s < 4; s++) set_slot(s, 1'b1, 4'b1111, 8'(s), 32'h100);

      // 1: reset with all slots valid, then first packet right after release
      cyc(); @(negedge clk);
      chk("rst1_exec_valid", 64'(eif.valid), 64'h0);
      chk("rst1_disp_ready", 64'(dif.ready), 64'h0);
      cyc(); @(negedge clk);
      chk("rst2_exec_valid", 64'(eif.valid), 64'h0);
      chk("rst2_disp_ready", 64'(dif.ready), 64'h0);
      cyc(); reset = 1'b0; @(negedge clk);
      chk("post_rst_valid", 64'(eif.valid), 64'h3);
      chk("post_rst_uuid0", 64'(eif.uuid[0]), 64'h0);
      chk("post_rst_uuid1", 64'(eif.uuid[1]), 64'h1);
      chk("post_rst_sop0", 64'(eif.sop[0]), 64'h1);
      chk("post_rst_ready", 64'(dif.ready), 64'h0);
      cyc(); for (int s = 0; s < 4; s++) dif.valid[s] = 1'b0; @(negedge clk);
      chk("drop_valid", 64'(eif.valid), 64'h0);

      // 2: slot 0 full mask, two packets
      cyc(); set_slot(0, 1'b1, 4'b1111, 8'h01, 32'hA0); eif.ready = 2'b11; @(negedge clk);
      chk("t2_p0_valid", 64'(eif.valid[0]), 64'h1);
      chk("t2_p0_pid", 64'(eif.pid[0]), 64'h0);
      chk("t2_p0_tmask", 64'(eif.tmask[0]), 64'h3);
      chk("t2_p0_rs1", 64'(eif.rs1_data[0]), lanes(32'hA0, 0));
      chk("t2_p0_rs2", 64'(eif.rs2_data[0]), lanes(32'hB0, 0));
      chk("t2_p0_sop", 64'(eif.sop[0]), 64'h1);
      chk("t2_p0_eop", 64'(eif.eop[0]), 64'h0);
      chk("t2_p0_wid", 64'(eif.wid[0]), 64'h4);
      chk("t2_p0_ready", 64'(dif.ready), 64'h0);
      chk("t2_blk1_idle", 64'(eif.valid[1]), 64'h0);
      cyc(); @(negedge clk);
      chk("t2_p1_pid", 64'(eif.pid[0]), 64'h1);
      chk("t2_p1_rs1", 64'(eif.rs1_data[0]), lanes(32'hA0, 1));
      chk("t2_p1_sop", 64'(eif.sop[0]), 64'h0);
      chk("t2_p1_eop", 64'(eif.eop[0]), 64'h1);
      chk("t2_p1_ready", 64'(dif.ready), 64'h1);
      cyc(); dif.valid[0] = 1'b0; @(negedge clk);
      chk("t2_after_ready", 64'(dif.ready), 64'h0);
      chk("t2_after_valid", 64'(eif.valid[0]), 64'h0);

      // 3: slot 2 upper-half-only mask, then empty mask
      cyc(); set_slot(2, 1'b1, 4'b1100, 8'h02, 32'h200); @(negedge clk);
      chk("t3a_pid", 64'(eif.pid[0]), 64'h1);
      chk("t3a_tmask", 64'(eif.tmask[0]), 64'h3);
      chk("t3a_sop_eop", 64'({eif.sop[0], eif.eop[0]}), 64'h3);
      chk("t3a_rs1", 64'(eif.rs1_data[0]), lanes(32'h200, 1));
      chk("t3a_wid", 64'(eif.wid[0]), 64'h2);
      chk("t3a_ready", 64'(dif.ready), 64'h4);
      cyc(); set_slot(2, 1'b1, 4'b0000, 8'h03, 32'h280); @(negedge clk);
      chk("t3b_uuid", 64'(eif.uuid[0]), 64'h03);
      chk("t3b_pid", 64'(eif.pid[0]), 64'h0);
      chk("t3b_tmask", 64'(eif.tmask[0]), 64'h0);
      chk("t3b_sop_eop", 64'({eif.sop[0], eif.eop[0]}), 64'h3);
      chk("t3b_ready", 64'(dif.ready), 64'h4);

      // 4: all four slots single-packet, both blocks alternate independently
      cyc();
      for (int s = 0; s < 4; s++) set_slot(s, 1'b1, 4'b0011, 8'(8'h10 + s), 32'h300);
      @(negedge clk);
      chk("t4a_uuid0", 64'(eif.uuid[0]), 64'h10);
      chk("t4a_uuid1", 64'(eif.uuid[1]), 64'h11);
      chk("t4a_ready", 64'(dif.ready), 64'h3);
      cyc(); @(negedge clk);
      chk("t4b_uuid0", 64'(eif.uuid[0]), 64'h12);
      chk("t4b_uuid1", 64'(eif.uuid[1]), 64'h13);
      chk("t4b_ready", 64'(dif.ready), 64'hC);
      cyc(); @(negedge clk);
      chk("t4c_uuid0", 64'(eif.uuid[0]), 64'h10);
      chk("t4c_uuid1", 64'(eif.uuid[1]), 64'h11);
      chk("t4c_ready", 64'(dif.ready), 64'h3);
      cyc(); @(negedge clk);
      chk("t4d_uuid0", 64'(eif.uuid[0]), 64'h12);
      chk("t4d_uuid1", 64'(eif.uuid[1]), 64'h13);
      chk("t4d_ready", 64'(dif.ready), 64'hC);

      // 5: multi-packet on slot 0 under backpressure, slot 2 waiting
      cyc();
      for (int s = 0; s < 4; s++) dif.valid[s] = 1'b0;
      set_slot(0, 1'b1, 4'b1111, 8'h20, 32'h400);
      set_slot(2, 1'b1, 4'b0011, 8'h22, 32'h500);
      eif.ready = 2'b00;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t5_stall_pid", 64'(eif.pid[0]), 64'h0);
         chk("t5_stall_uuid", 64'(eif.uuid[0]), 64'h20);
         chk("t5_stall_rs1", 64'(eif.rs1_data[0]), lanes(32'h400, 0));
         chk("t5_stall_ready", 64'(dif.ready), 64'h0);
         cyc();
      end
      eif.ready = 2'b01; @(negedge clk);
      chk("t5_p0_pid", 64'(eif.pid[0]), 64'h0);
      chk("t5_p0_sop", 64'(eif.sop[0]), 64'h1);
      chk("t5_p0_ready", 64'(dif.ready), 64'h0);
      cyc(); @(negedge clk);
      chk("t5_p1_pid", 64'(eif.pid[0]), 64'h1);
      chk("t5_p1_uuid", 64'(eif.uuid[0]), 64'h20);
      chk("t5_p1_eop", 64'(eif.eop[0]), 64'h1);
      chk("t5_p1_ready", 64'(dif.ready), 64'h1);
      cyc(); dif.valid[0] = 1'b0; @(negedge clk);
      chk("t5_s2_uuid", 64'(eif.uuid[0]), 64'h22);
      chk("t5_s2_ready", 64'(dif.ready), 64'h4);

      // 6: reset between pid0 and pid1, fresh instruction restarts at sop
      cyc(); dif.valid[2] = 1'b0; set_slot(0, 1'b1, 4'b1111, 8'h30, 32'h600); @(negedge clk);
      chk("t6_p0_pid", 64'(eif.pid[0]), 64'h0);
      chk("t6_p0_uuid", 64'(eif.uuid[0]), 64'h30);
      cyc(); reset = 1'b1; @(negedge clk);
      chk("t6_rst_valid", 64'(eif.valid), 64'h0);
      chk("t6_rst_ready", 64'(dif.ready), 64'h0);
      cyc(); reset = 1'b0; set_slot(0, 1'b1, 4'b1111, 8'h31, 32'h700); @(negedge clk);
      chk("t6_new_pid", 64'(eif.pid[0]), 64'h0);
      chk("t6_new_sop", 64'(eif.sop[0]), 64'h1);
      chk("t6_new_eop", 64'(eif.eop[0]), 64'h0);
      chk("t6_new_uuid", 64'(eif.uuid[0]), 64'h31);
      chk("t6_new_rs1", 64'(eif.rs1_data[0]), lanes(32'h700, 0));
      chk("t6_new_ready", 64'(dif.ready), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
